sram_resp: RTL and testbench
============================

# sram_resp

Synthesizable, cycle-accurate responder for the external SRAM pin interface of the SoC. One instance sits on the IRAM pins and one on the DRAM pins in simulation and FPGA-BRAM builds. Each instance decodes the single-port SRAM strobes, performs byte-enabled writes into an internal word array, and returns read data through a fixed-latency pipeline. It flags out-of-range accesses and can optionally count accesses.

## Interface
- ADDR_W, 20, pin word-address width.
- DATA_W, 32, data width; must be a multiple of 8.
- DEPTH_W, 16, log2 of implemented words. Must be ≤ ADDR_W.
- RD_LAT, 1, read latency in cycles; legal range 1..4.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- CE_N  in  1  chip enable, active low.
- OE_N  in  1  output enable, active low.
- WE_N  in  1  write enable, active low.
- BE_N  in  DATA_W/8  byte enables, active low; bit i covers bits [8i+7:8i].
- PADDR  in  ADDR_W  word address.
- WDATA  in  DATA_W  write data.
- RDATA  out  DATA_W  read data; 0 whenever RVALID=0.
- RVALID  out  1  RDATA carries a completed read.
- ERROR  out  1  sticky out-of-range flag.
- RD_CNT  out  32  completed-read count.
- WR_CNT  out  32  accepted-write count.

## Operation
- Request decode is sampled every rising edge:
  - write: CE_N=0 and WE_N=0. OE_N is ignored.
  - read: CE_N=0, WE_N=1, OE_N=0.
  - idle: anything else.
- Write: for each i with BE_N[i]=0, mem[PADDR][8i+:8] ← WDATA[8i+:8]. A write with all BE_N=1 changes no data but still counts in WR_CNT.
- Read: the array word is captured in the issue cycle and carried through an RD_LAT-deep pipeline together with a valid bit and a registered copy of BE_N. On output, bytes whose BE_N was 1 read as 8'h00.
- Out of range: PADDR[ADDR_W-1:DEPTH_W] ≠ 0.
  - A write is suppressed.
  - A read still occupies the pipeline and returns all-zero data with RVALID=1.
  - ERROR sets and stays set until RST.
- Back-to-back requests: one request per cycle, no stall. The pipeline accepts a new read every cycle.
- Write followed by a read of the same address on the next cycle returns the new data.
- Read followed by a write to the same address while the read is in flight returns the old data, because the word was captured at issue.
- Counters wrap modulo 2^32.
  - RD_CNT increments when RVALID is asserted.
  - WR_CNT increments on each accepted write, including out-of-range writes.

## Timing
- Read issued at edge N: RDATA/RVALID are valid after edge N+RD_LAT and remain valid for one cycle.
- A write issued at edge N is visible to a read issued at edge N+1.
- Reset values: RDATA=0, RVALID=0, ERROR=0, RD_CNT=0, WR_CNT=0, all pipeline valid bits 0. Memory contents are not cleared.
- RST asserted while reads are in flight flushes them; none return.
- RST asserted in the same cycle as a write request: reset wins and the write is suppressed.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SRAM_RESP_STATS_EN defined: RD_CNT and WR_CNT operate as described above.
- SRAM_RESP_STATS_EN undefined: the counter registers are not built, RD_CNT and WR_CNT are tied to 0, and the ports remain present.

## Structure
- Shared package sram_resp_pkg holds:
  - the request-kind enum (REQ_IDLE, REQ_READ, REQ_WRITE);
  - RD_LAT_MAX = 4;
  - the pipeline-stage struct {valid, oor, be_n, data}.
- Sub-module sram_resp_rdpipe implements the parameterized RD_LAT-stage read pipeline with flush on RST.
- The word array and decode logic stay in sram_resp.

## Test plan
- Reset, then write 32'hDEADBEEF to PADDR 0x00010 with BE_N=4'b0000, then read it at RD_LAT=1 → one cycle later RVALID=1, RDATA=32'hDEADBEEF. RD_CNT=1, WR_CNT=1.
- Preload 32'h11223344, then write 32'hAABBCCDD with BE_N=4'b1010, then read with BE_N=0 → RDATA=32'h11BB33DD. Read again with BE_N=4'b0011 → RDATA=32'h11BB0000.
- RD_LAT=3, back-to-back reads of addresses 1, 2, 3 (each holding 100+addr) → RVALID high for 3 consecutive cycles starting 3 cycles after the first issue, returning 101, 102, 103.
- Read of address 5 (holding 32'h5) followed next cycle by a write of 32'h6 to address 5, with RD_LAT=2 → read returns 32'h5. A subsequent read returns 32'h6.
- Write with PADDR=20'h10000 at DEPTH_W=16 → ERROR=1 from the next cycle. Address 0 is unchanged. A read of 20'h10000 returns 0 with RVALID=1.
- Issue a read, then assert RST on the next edge with RD_LAT=2 → RVALID never asserts. All outputs are 0 and ERROR is cleared. Memory keeps its prior contents, confirmed by a read after reset.

Source files
------------

// File: rtl/sram_resp_pkg.sv
// Shared types for the SRAM pin responder: request kinds, the read-pipeline
// stage record and build limits. Optional statistics use SRAM_RESP_STATS_EN.
package sram_resp_pkg;

    localparam int RD_LAT_MAX = 4;
    // Stage records are sized for the widest supported bus; narrower
    // instances zero-extend into them.
    localparam int DATA_W_MAX = 128;
    localparam int BE_W_MAX   = DATA_W_MAX / 8;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_READ,
        REQ_WRITE
    } req_kind_e;

    typedef struct packed {
        logic                  valid;
        logic                  oor;
        logic [BE_W_MAX-1:0]   be_n;
        logic [DATA_W_MAX-1:0] data;
    } stage_t;

    // Write has priority over read; OE_N only matters when WE_N is high.
    function automatic req_kind_e decode_req(input logic ce_n,
                                             input logic oe_n,
                                             input logic we_n);
        if (ce_n) return REQ_IDLE;
        if (!we_n) return REQ_WRITE;
        if (!oe_n) return REQ_READ;
        return REQ_IDLE;
    endfunction

endpackage

// File: rtl/sram_resp_rdpipe.sv
// RD_LAT-stage read pipeline with a registered, byte-masked output;
// synchronous reset flushes every stage so no in-flight read returns.
module sram_resp_rdpipe
    import sram_resp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  stage_t            issue,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              fire
);

    localparam int BE_W = DATA_W / 8;

    stage_t            stg [RD_LAT];
    stage_t            last;
    logic [DATA_W-1:0] masked;

    assign last = stg[RD_LAT-1];
    assign fire = last.valid;

    always_comb begin
        masked = '0;
        for (int i = 0; i < BE_W; i++) begin
            masked[8*i +: 8] = last.be_n[i] ? 8'h00 : last.data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stg[i] <= '0;
            end
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            stg[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                stg[i] <= stg[i-1];
            end
            rvalid <= last.valid;
            // Out-of-range reads complete with zero data.
            rdata  <= (last.valid && !last.oor) ? masked : '0;
        end
    end

    generate
        if (DATA_W < DATA_W_MAX) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^{last.data[DATA_W_MAX-1:DATA_W], last.be_n[BE_W_MAX-1:BE_W]};
        end
    endgenerate

endmodule

// File: rtl/sram_resp.sv
// SRAM pin-interface responder: strobe decode, byte-enabled word array,
// fixed-latency reads, sticky range error. Counters built under SRAM_RESP_STATS_EN.
module sram_resp
    import sram_resp_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 16,
    parameter int RD_LAT  = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CE_N,
    input  logic                OE_N,
    input  logic                WE_N,
    input  logic [DATA_W/8-1:0] BE_N,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W-1:0]   RDATA,
    output logic                RVALID,
    output logic                ERROR,
    output logic [31:0]         RD_CNT,
    output logic [31:0]         WR_CNT
);

    localparam int BE_W  = DATA_W / 8;
    localparam int WORDS = 1 << DEPTH_W;

    logic [DATA_W-1:0]  mem [WORDS];
    req_kind_e          req;
    logic               oor;
    logic [DEPTH_W-1:0] word_addr;
    stage_t             issue;
    logic               out_fire;
    logic               error_q;

    assign req       = decode_req(CE_N, OE_N, WE_N);
    assign word_addr = PADDR[DEPTH_W-1:0];

    generate
        if (DEPTH_W < ADDR_W) begin : g_oor
            assign oor = |PADDR[ADDR_W-1:DEPTH_W];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    // The word is captured at issue, so a later write cannot alter an in-flight read.
    always_comb begin
        issue       = '0;
        issue.valid = (req == REQ_READ);
        issue.oor   = oor;
        issue.be_n  = BE_W_MAX'(BE_N);
        issue.data  = DATA_W_MAX'(mem[word_addr]);
    end

    // Memory is never cleared; reset only blocks a coincident write.
    always_ff @(posedge CLK) begin
        if (!RST && req == REQ_WRITE && !oor) begin
            for (int i = 0; i < BE_W; i++) begin
                if (!BE_N[i]) begin
                    mem[word_addr][8*i +: 8] <= WDATA[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            error_q <= 1'b0;
        end else if (oor && req != REQ_IDLE) begin
            error_q <= 1'b1;
        end
    end

    assign ERROR = error_q;

    sram_resp_rdpipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk    (CLK),
        .rst    (RST),
        .issue  (issue),
        .rdata  (RDATA),
        .rvalid (RVALID),
        .fire   (out_fire)
    );

`ifdef SRAM_RESP_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    // RD_CNT advances on the same edge that raises RVALID.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (out_fire) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (req == REQ_WRITE) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign RD_CNT = rd_cnt_q;
    assign WR_CNT = wr_cnt_q;
`else
    logic unused_fire;
    assign unused_fire = out_fire;
    assign RD_CNT      = '0;
    assign WR_CNT      = '0;
`endif

endmodule

// File: tb/tb_sram_resp.sv
// Bench for sram_resp: three instances (RD_LAT 1..3) share one stimulus stream
// and are checked every cycle against a word-level reference model.
module tb_sram_resp;
    import sram_resp_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce_n, oe_n, we_n;
    logic [3:0]    be_n;
    logic [AW-1:0] paddr;
    logic [DW-1:0] wdata;

    logic [DW-1:0] rdata  [NI];
    logic          rvalid [NI];
    logic          error  [NI];
    logic [31:0]   rd_cnt [NI];
    logic [31:0]   wr_cnt [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sram_resp #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_W(16), .RD_LAT(g + 1)) u_dut (
            .CLK(clk), .RST(rst), .CE_N(ce_n), .OE_N(oe_n), .WE_N(we_n),
            .BE_N(be_n), .PADDR(paddr), .WDATA(wdata),
            .RDATA(rdata[g]), .RVALID(rvalid[g]), .ERROR(error[g]),
            .RD_CNT(rd_cnt[g]), .WR_CNT(wr_cnt[g])
        );
    end

    // Reference model: sparse word memory plus per-instance expected responses.
    logic [DW-1:0] mem_m [int];
    logic [DW-1:0] exp_q [NI][$];
    int            exp_t [NI][$];
    bit            err_m;
    int unsigned   rd_m [NI];
    int unsigned   wr_m;
    int            cyc;
    int            n_checks;
    int            n_fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_word(input int a);
        return mem_m.exists(a) ? mem_m[a] : '0;
    endfunction

    // Advance one clock with the inputs already driven, update the model, check all outputs.
    task automatic step();
        bit            is_wr, is_rd, oob;
        int            a;
        logic [DW-1:0] word, resp, ev;
        logic [31:0]   erd, ewr;
        bit            evv;
        is_wr = !ce_n && !we_n;
        is_rd = !ce_n && we_n && !oe_n;
        oob   = (paddr >= 20'h10000);
        a     = int'(paddr);
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int g = 0; g < NI; g++) begin
                exp_q[g].delete();
                exp_t[g].delete();
                rd_m[g] = 0;
            end
            err_m = 0;
            wr_m  = 0;
        end else begin
            if (is_rd) begin
                resp = '0;
                word = model_word(a);
                if (!oob) begin
                    for (int i = 0; i < 4; i++) begin
                        if (!be_n[i]) resp[8*i +: 8] = word[8*i +: 8];
                    end
                end
                for (int g = 0; g < NI; g++) begin
                    exp_q[g].push_back(resp);
                    exp_t[g].push_back(cyc + g + 1);
                end
            end
            if (is_wr) begin
                wr_m++;
                if (!oob) begin
                    word = model_word(a);
                    for (int i = 0; i < 4; i++) begin
                        if (!be_n[i]) word[8*i +: 8] = wdata[8*i +: 8];
                    end
                    mem_m[a] = word;
                end
            end
            if ((is_rd || is_wr) && oob) err_m = 1;
        end
        #1;
        for (int g = 0; g < NI; g++) begin
            evv = 0;
            ev  = '0;
            if (exp_t[g].size() > 0 && exp_t[g][0] == cyc) begin
                evv = 1;
                ev  = exp_q[g].pop_front();
                void'(exp_t[g].pop_front());
                rd_m[g]++;
            end
`ifdef SRAM_RESP_STATS_EN
            erd = rd_m[g];
            ewr = wr_m;
`else
            erd = 0;
            ewr = 0;
`endif
            chk($sformatf("rvalid_lat%0d_c%0d", g + 1, cyc), {31'b0, rvalid[g]}, {31'b0, evv});
            chk($sformatf("rdata_lat%0d_c%0d", g + 1, cyc), rdata[g], ev);
            chk($sformatf("error_lat%0d_c%0d", g + 1, cyc), {31'b0, error[g]}, {31'b0, err_m});
            chk($sformatf("rd_cnt_lat%0d_c%0d", g + 1, cyc), rd_cnt[g], erd);
            chk($sformatf("wr_cnt_lat%0d_c%0d", g + 1, cyc), wr_cnt[g], ewr);
        end
    endtask

    task automatic drive(input logic c, input logic o, input logic w, input logic [3:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        ce_n  = c;
        oe_n  = o;
        we_n  = w;
        be_n  = be;
        paddr = a;
        wdata = d;
        step();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        drive(1'b0, 1'b1, 1'b0, be, a, d);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [3:0] be);
        drive(1'b0, 1'b0, 1'b1, be, a, $urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b1, 4'hF, '0, '0);
    endtask

    initial begin
        int            r;
        logic [AW-1:0] a;
        rst = 1'b1;
        n_checks = 0;
        n_fails  = 0;
        cyc = 0;
        idle(2);
        rst = 1'b0;

        // Full write then read at latency 1.
        wr(20'h00010, 32'hDEADBEEF, 4'b0000);
        rd(20'h00010, 4'b0000);
        idle(1);
        chk("t1_rdata", rdata[0], 32'hDEADBEEF);
        chk("t1_rvalid", {31'b0, rvalid[0]}, 32'd1);
`ifdef SRAM_RESP_STATS_EN
        chk("t1_rd_cnt", rd_cnt[0], 32'd1);
        chk("t1_wr_cnt", wr_cnt[0], 32'd1);
`endif

        for (int i = 0; i < 32; i++) wr(AW'(i), 32'd100 + 32'(i), 4'b0000);

        // Byte-enabled write and masked reads.
        wr(20'd7, 32'h11223344, 4'b0000);
        wr(20'd7, 32'hAABBCCDD, 4'b1010);
        rd(20'd7, 4'b0000);
        rd(20'd7, 4'b0011);
        chk("t2_full", rdata[0], 32'h11BB33DD);
        idle(1);
        chk("t2_masked", rdata[0], 32'h11BB0000);
        idle(3);

        // Back-to-back reads at latency 3.
        rd(20'd1, 4'b0000);
        rd(20'd2, 4'b0000);
        rd(20'd3, 4'b0000);
        idle(1);
        chk("t3_first", rdata[2], 32'd101);
        idle(1);
        chk("t3_second", rdata[2], 32'd102);
        idle(1);
        chk("t3_third", rdata[2], 32'd103);
        idle(1);
        chk("t3_done", {31'b0, rvalid[2]}, 32'd0);

        // Read followed by a write to the same word while in flight.
        wr(20'd5, 32'h5, 4'b0000);
        rd(20'd5, 4'b0000);
        wr(20'd5, 32'h6, 4'b0000);
        idle(1);
        chk("t4_old", rdata[1], 32'h5);
        rd(20'd5, 4'b0000);
        idle(2);
        chk("t4_new", rdata[1], 32'h6);

        // Out-of-range write and read.
        wr(20'h10000, 32'hCAFEF00D, 4'b0000);
        chk("t5_error", {31'b0, error[0]}, 32'd1);
        rd(20'h00000, 4'b0000);
        idle(1);
        chk("t5_addr0", rdata[0], 32'd100);
        rd(20'h10000, 4'b0000);
        idle(1);
        chk("t5_oor_valid", {31'b0, rvalid[0]}, 32'd1);
        chk("t5_oor_data", rdata[0], 32'd0);

        // Reset flushes an in-flight read and blocks a coincident write.
        rd(20'd3, 4'b0000);
        rst = 1'b1;
        wr(20'd9, 32'h12345678, 4'b0000);
        rst = 1'b0;
        chk("t6_error_clr", {31'b0, error[1]}, 32'd0);
        idle(1);
        chk("t6_flushed", {31'b0, rvalid[1]}, 32'd0);
        idle(2);
        rd(20'd3, 4'b0000);
        rd(20'd9, 4'b0000);
        idle(1);
        chk("t6_mem_kept", rdata[1], 32'd103);
        idle(1);
        chk("t6_write_blocked", rdata[1], 32'd109);
        idle(3);

        // Randomized traffic over the preloaded range with occasional faults and resets.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            a = ($urandom_range(0, 15) == 0) ? (20'h10000 | AW'($urandom_range(0, 20'hFFFF)))
                                             : AW'($urandom_range(0, 31));
            r = $urandom_range(0, 9);
            if (r <= 3)      rd(a, 4'($urandom_range(0, 15)));
            else if (r <= 6) wr(a, $urandom, 4'($urandom_range(0, 15)));
            else if (r == 7) drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'hF, a, $urandom);
            else if (r == 8) drive(1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 15)), a, $urandom);
            else             idle(1);
        end
        rst = 1'b0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
